counter_cin_sched: RTL and testbench

//  Sequencer for the 4-bit carry-in counter IP (cin/clock/cout/q).
//  - Issues one-cycle cin pulses every DIV clocks.
//  - Counts counter carries (cin & cout).
//  - Stops after TARGET carries and reports completion.

---
 rtl/counter_cin_sched.sv | 155 +++++++++++++++
 tb/tb_counter_cin_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cin_sched.sv
// ---------------------------------------------------------------------------
// counter_cin_sched
//   Sequencer for the 4-bit carry-in counter IP. It drives the counter's cin
//   with one-cycle pulses every div clocks and counts the carries the counter
//   produces (cin & cout). After target carries it stops and reports done.
//   An abort (stop) returns to IDLE at once with no done pulse.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      start request, level sampled at the edge
//   stop       in   1      abort request, level sampled at the edge
//   div        in   DIV_W  clocks between cin pulses (0 behaves as 1), captured at start
//   target     in   TGT_W  carries to collect, captured at start
//   cnt_cin    out  1      registered cin to the counter
//   cnt_cout   in   1      counter cout (combinational in the IP)
//   cnt_q      in   CNT_W  counter value, only snapshotted
//   busy       out  1      high while running
//   done       out  1      one-cycle completion pulse
//   carry_cnt  out  TGT_W  carries collected in the current/last run
//   q_snap     out  CNT_W  cnt_q captured at completion or abort
// ---------------------------------------------------------------------------
module counter_cin_sched #(
    parameter int CNT_W = 4,
    parameter int DIV_W = 16,
    parameter int TGT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [TGT_W-1:0] target,
    output logic             cnt_cin,
    input  logic             cnt_cout,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             busy,
    output logic             done,
    output logic [TGT_W-1:0] carry_cnt,
    output logic [CNT_W-1:0] q_snap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] presc_reg, presc_next;
    logic [DIV_W-1:0] div_reg,   div_next;
    logic [TGT_W-1:0] tgt_reg,   tgt_next;
    logic [TGT_W-1:0] carry_reg, carry_next;
    logic [CNT_W-1:0] qsnap_reg, qsnap_next;
    logic             cin_reg,   cin_next;
    logic             done_reg,  done_next;

    // Saturating increment of the carry counter; target bounds it in practice.
    logic [TGT_W-1:0] carry_inc;
    logic             carry_hit;

    assign carry_inc = (&carry_reg) ? carry_reg : carry_reg + TGT_W'(1);
    // A carry is only ours if we were driving cin in that cycle.
    assign carry_hit = cin_reg & cnt_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            presc_reg <= '0;
            div_reg   <= DIV_W'(1);
            tgt_reg   <= '0;
            carry_reg <= '0;
            qsnap_reg <= '0;
            cin_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            div_reg   <= div_next;
            tgt_reg   <= tgt_next;
            carry_reg <= carry_next;
            qsnap_reg <= qsnap_next;
            cin_reg   <= cin_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        div_next   = div_reg;
        tgt_next   = tgt_reg;
        carry_next = carry_reg;
        qsnap_next = qsnap_reg;
        cin_next   = 1'b0;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // start wins over a simultaneous stop; stop alone is a no-op here
                if (start) begin
                    div_next   = (div == '0) ? DIV_W'(1) : div;
                    tgt_next   = target;
                    carry_next = '0;
                    presc_next = '0;
                    if (target == '0) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // Abort beats a final carry on the same edge; count is held.
                    state_next = ST_IDLE;
                    qsnap_next = cnt_q;
                end else if (carry_hit && (carry_inc == tgt_reg)) begin
                    carry_next = carry_inc;
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                    qsnap_next = cnt_q;
                end else begin
                    if (carry_hit) begin
                        carry_next = carry_inc;
                    end
                    // Pulse goes out in the cycle after the prescaler wraps.
                    if (presc_reg == div_reg - DIV_W'(1)) begin
                        presc_next = '0;
                        cin_next   = 1'b1;
                    end else begin
                        presc_next = presc_reg + DIV_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cnt_cin   = cin_reg;
    assign busy      = (state_reg == ST_RUN);
    assign done      = done_reg;
    assign carry_cnt = carry_reg;
    assign q_snap    = qsnap_reg;

endmodule

// File: tb/tb_counter_cin_sched.sv
// ---------------------------------------------------------------------------
// tb_counter_cin_sched
//   Drives counter_cin_sched together with a small model of the 4-bit
//   carry-in counter IP, and compares every output each cycle against a
//   reference that works from the run's start edge with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_counter_cin_sched;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] div = '0;
    logic [7:0]  target = '0;
    logic        cnt_cin;
    logic        cnt_cout;
    logic [3:0]  cnt_q;
    logic        busy;
    logic        done;
    logic [7:0]  carry_cnt;
    logic [3:0]  q_snap;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // reference model state
    int m_state = M_IDLE;
    int m_k     = 0;
    int m_div   = 1;
    int m_tgt   = 0;
    int m_carry = 0;
    int m_qsnap = 0;
    int m_cin   = 0;
    int m_done  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    // 4-bit carry-in counter IP: no clear, so the bench clears it with reset.
    logic [3:0] cq;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cq <= 4'd0;
        else if (cnt_cin) cq <= cq + 4'd1;
    end
    assign cnt_q    = cq;
    assign cnt_cout = cnt_cin && (cq == 4'hf);

    counter_cin_sched #(.CNT_W(4), .DIV_W(16), .TGT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .div       (div),
        .target    (target),
        .cnt_cin   (cnt_cin),
        .cnt_cout  (cnt_cout),
        .cnt_q     (cnt_q),
        .busy      (busy),
        .done      (done),
        .carry_cnt (carry_cnt),
        .q_snap    (q_snap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_carry = 0;
        m_qsnap = 0;
        m_cin   = 0;
        m_done  = 0;
    endtask

    // Advance the reference across the next edge using the inputs now applied.
    task automatic model_step();
        int e;
        bit cout_now;
        cyc++;
        e = cyc;
        cout_now = (m_cin != 0) && (cq == 4'hf);
        case (m_state)
            M_IDLE: begin
                m_done = 0;
                m_cin  = 0;
                if (start) begin
                    m_div   = (div == 0) ? 1 : int'(div);
                    m_tgt   = int'(target);
                    m_carry = 0;
                    m_k     = e;
                    if (m_tgt == 0) begin
                        m_state = M_DONE;
                        m_done  = 1;
                    end else begin
                        m_state = M_RUN;
                    end
                end
            end
            M_RUN: begin
                m_done = 0;
                if (stop) begin
                    m_state = M_IDLE;
                    m_cin   = 0;
                    m_qsnap = int'(cq);
                end else begin
                    if (cout_now) m_carry = (m_carry < 255) ? m_carry + 1 : 255;
                    if (cout_now && m_carry == m_tgt) begin
                        m_state = M_DONE;
                        m_done  = 1;
                        m_cin   = 0;
                        m_qsnap = int'(cq);
                    end else begin
                        // n-th pulse occupies the cycle starting at edge k + n*div
                        m_cin = (((e - m_k) % m_div) == 0) ? 1 : 0;
                    end
                end
            end
            default: begin
                m_state = M_IDLE;
                m_done  = 0;
                m_cin   = 0;
            end
        endcase
    endtask

    // One clock: check what the last edge produced, then apply new inputs.
    task automatic cycle(input logic s, input logic p, input logic [15:0] d, input logic [7:0] t);
        @(negedge clk);
        chk("cnt_cin", 32'(cnt_cin), 32'(m_cin));
        chk("busy", 32'(busy), 32'(m_state == M_RUN));
        chk("done", 32'(done), 32'(m_done));
        chk("carry_cnt", 32'(carry_cnt), 32'(m_carry));
        chk("q_snap", 32'(q_snap), 32'(m_qsnap));
        if (cnt_cin) pulses++;
        start  = s;
        stop   = p;
        div    = d;
        target = t;
        model_step();
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_cin", 32'(cnt_cin), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_carry", 32'(carry_cnt), 32'd0);
        chk("rst_qsnap", 32'(q_snap), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_step();
    endtask

    task automatic run_to_idle(input logic [15:0] d, input logic [7:0] t);
        int n = 0;
        while (m_state != M_IDLE && n < 2000) begin
            cycle(1'b0, 1'b0, d, t);
            n++;
        end
        if (n >= 2000) chk("run_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        bit s, p;
        do_reset();

        // div=5, target=2 from q=0: 32 pulses, snapshot at q=15
        cycle(1'b1, 1'b0, 16'd5, 8'd2);
        pulses = 0;
        run_to_idle(16'd5, 8'd2);
        cycle(1'b0, 1'b0, 16'd5, 8'd2);
        chk("t2_pulses", 32'(pulses), 32'd32);
        chk("t2_qsnap", 32'(q_snap), 32'd15);
        chk("t2_carry", 32'(carry_cnt), 32'd2);

        // div=0 behaves as 1, target=1: 16 contiguous pulses
        do_reset();
        cycle(1'b1, 1'b0, 16'd0, 8'd1);
        pulses = 0;
        run_to_idle(16'd0, 8'd1);
        cycle(1'b0, 1'b0, 16'd0, 8'd1);
        chk("t3_pulses", 32'(pulses), 32'd16);

        // target=0: straight to DONE, no pulses
        pulses = 0;
        cycle(1'b1, 1'b0, 16'd3, 8'd0);
        cycle(1'b0, 1'b0, 16'd3, 8'd0);
        cycle(1'b0, 1'b0, 16'd3, 8'd0);
        chk("t4_pulses", 32'(pulses), 32'd0);

        // stop at k+40 with div=5, target=3; start re-pulsed at k+12 with div=2
        do_reset();
        cycle(1'b1, 1'b0, 16'd5, 8'd3);
        for (int j = 1; j < 40; j++) cycle(j == 12, 1'b0, (j == 12) ? 16'd2 : 16'd5, 8'd3);
        cycle(1'b0, 1'b1, 16'd5, 8'd3);
        cycle(1'b0, 1'b0, 16'd5, 8'd3);
        cycle(1'b0, 1'b0, 16'd5, 8'd3);

        // stop on the same edge as the final carry (div=1, target=1)
        do_reset();
        cycle(1'b1, 1'b0, 16'd1, 8'd1);
        repeat (16) cycle(1'b0, 1'b0, 16'd1, 8'd1);
        cycle(1'b0, 1'b1, 16'd1, 8'd1);
        cycle(1'b0, 1'b0, 16'd1, 8'd1);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

        // reset in the middle of a run
        cycle(1'b1, 1'b0, 16'd3, 8'd2);
        repeat (20) cycle(1'b0, 1'b0, 16'd3, 8'd2);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 2999) == 0) do_reset();
            if (m_state == M_IDLE) begin
                s = ($urandom_range(0, 3) == 0);
                p = ($urandom_range(0, 3) == 0);
            end else begin
                s = ($urandom_range(0, 40) == 0);
                if (m_state == M_RUN && m_cin != 0 && cq == 4'hf && m_carry + 1 == m_tgt)
                    p = ($urandom_range(0, 1) == 0);
                else
                    p = ($urandom_range(0, 299) == 0);
            end
            cycle(s, p, 16'($urandom_range(0, 6)), 8'($urandom_range(0, 3)));
        end
        cycle(1'b0, 1'b0, 16'd1, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
